// File: rtl/pipe_check_pkg.sv
// Shared definitions for the pipeline check monitor.
//   - parameter defaults for data, register address, entry count and cycle widths
//   - run-control FSM state encoding
//   - idx_width(): entry-index width, never narrower than one bit
package pipe_check_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_NUM_CHECKS = 8;
  localparam int DEF_CYCLE_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/check_table.sv
// Check-entry storage: NUM_CHECKS entries of {enable, register address,
// expected value}.
//   clk, rst_n                 : clock, synchronous active-low reset (enables only)
//   we, wr_idx, wr_en,
//   wr_addr, wr_data           : single write port
//   rd_idx                     : read index
//   rd_en, rd_addr, rd_data    : combinational read of entry rd_idx
//                                (zeros when rd_idx is past the last entry)
module check_table
  import pipe_check_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int NUM_CHECKS = DEF_NUM_CHECKS,
  parameter int IDX_W      = idx_width(NUM_CHECKS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  rd_en,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0]     rd_data
);

  localparam logic [IDX_W:0] NUM_C = NUM_CHECKS[IDX_W:0];

  // Enables must clear on reset, so they live in flops; address and
  // expected value need no reset and are kept as plain arrays.
  logic [NUM_CHECKS-1:0]  en_reg;
  logic [REG_ADDR_W-1:0]  addr_mem [NUM_CHECKS];
  logic [DATA_W-1:0]      data_mem [NUM_CHECKS];

  for (genvar gi = 0; gi < NUM_CHECKS; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        en_reg[gi] <= 1'b0;
      end else if (we && (wr_idx == IDX_W'(gi))) begin
        en_reg[gi] <= wr_en;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      addr_mem[wr_idx] <= wr_addr;
      data_mem[wr_idx] <= wr_data;
    end
  end

  // Combinational read: the monitor registers the address itself, so a
  // registered read here would add a cycle to every slot.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    rd_data = '0;
    if ({1'b0, rd_idx} < NUM_C) begin
      rd_en   = en_reg[rd_idx];
      rd_addr = addr_mem[rd_idx];
      rd_data = data_mem[rd_idx];
    end
  end

endmodule

// File: rtl/pipe_check_monitor.sv
// Pipeline end-of-run checker. After a start pulse it counts cycles up to
// target_cycle, then walks the check table one entry per cycle, reading the
// register file and comparing against the expected values.
//   clk, rst_n        : clock, synchronous active-low reset
//   cfg_we/idx/en/
//   cfg_addr/cfg_data : check-entry write (accepted in IDLE or DONE only)
//   target_cycle      : last counting cycle (0 or 1 = check immediately)
//   start             : start pulse (accepted in IDLE or DONE only)
//   rf_rd_addr        : registered register-file read address
//   rf_rd_data        : combinational register-file read data
//   busy, done, pass  : run active, results valid, all enabled entries matched
//   fail_count        : mismatching enabled entries (saturating)
//   first_fail_idx/
//   first_fail_data   : entry index and actual value of the first mismatch
//   cycle_count       : current run cycle, frozen outside COUNT
module pipe_check_monitor
  import pipe_check_pkg::*;
#(
  parameter  int DATA_W     = DEF_DATA_W,
  parameter  int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter  int NUM_CHECKS = DEF_NUM_CHECKS,
  parameter  int CYCLE_W    = DEF_CYCLE_W,
  localparam int IDX_W      = idx_width(NUM_CHECKS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic                  cfg_en,
  input  logic [REG_ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0]     cfg_data,
  input  logic [CYCLE_W-1:0]    target_cycle,
  input  logic                  start,
  output logic [REG_ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0]     rf_rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [IDX_W:0]        fail_count,
  output logic [IDX_W-1:0]      first_fail_idx,
  output logic [DATA_W-1:0]     first_fail_data,
  output logic [CYCLE_W-1:0]    cycle_count
);

  localparam logic [IDX_W:0] NUM_C = NUM_CHECKS[IDX_W:0];

  state_t              state_reg;
  logic [CYCLE_W-1:0]  target_reg;
  logic [IDX_W:0]      chk_cnt_reg;     // CHECK cycle number, 0..NUM_CHECKS

  // Entry whose address is currently on rf_rd_addr.
  logic                cur_en_reg;
  logic [DATA_W-1:0]   cur_exp_reg;
  logic [IDX_W-1:0]    cur_idx_reg;

  // Sampled read result, compared one cycle after the read.
  logic                cmp_valid_reg;
  logic                cmp_en_reg;
  logic [DATA_W-1:0]   cmp_exp_reg;
  logic [DATA_W-1:0]   cmp_act_reg;
  logic [IDX_W-1:0]    cmp_idx_reg;

  logic                tbl_we;
  logic [IDX_W-1:0]    tbl_rd_idx;
  logic                tbl_rd_en;
  logic [REG_ADDR_W-1:0] tbl_rd_addr;
  logic [DATA_W-1:0]   tbl_rd_data;

  logic [IDX_W:0]      next_slot;
  logic                next_slot_ok;
  logic                cmp_mismatch;

  // Configuration is frozen while a run is in progress.
  assign tbl_we = cfg_we && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

  // The table is read one slot ahead: entry 0 while leaving COUNT, entry
  // k+1 during CHECK cycle k, so its address lands on rf_rd_addr in time.
  always_comb begin
    next_slot = '0;
    if (state_reg == ST_CHECK) begin
      next_slot = chk_cnt_reg + 1'b1;
    end
    next_slot_ok = (next_slot < NUM_C);
    cmp_mismatch = cmp_valid_reg && cmp_en_reg && (cmp_act_reg != cmp_exp_reg);
  end

  assign tbl_rd_idx = next_slot[IDX_W-1:0];

  check_table #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W),
    .NUM_CHECKS (NUM_CHECKS),
    .IDX_W      (IDX_W)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (tbl_we),
    .wr_idx  (cfg_idx),
    .wr_en   (cfg_en),
    .wr_addr (cfg_addr),
    .wr_data (cfg_data),
    .rd_idx  (tbl_rd_idx),
    .rd_en   (tbl_rd_en),
    .rd_addr (tbl_rd_addr),
    .rd_data (tbl_rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      target_reg      <= '0;
      chk_cnt_reg     <= '0;
      cur_en_reg      <= 1'b0;
      cur_exp_reg     <= '0;
      cur_idx_reg     <= '0;
      cmp_valid_reg   <= 1'b0;
      cmp_en_reg      <= 1'b0;
      cmp_exp_reg     <= '0;
      cmp_act_reg     <= '0;
      cmp_idx_reg     <= '0;
      rf_rd_addr      <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      fail_count      <= '0;
      first_fail_idx  <= '0;
      first_fail_data <= '0;
      cycle_count     <= '0;
    end else begin
      cmp_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            done            <= 1'b0;
            pass            <= 1'b0;
            fail_count      <= '0;
            first_fail_idx  <= '0;
            first_fail_data <= '0;
            cycle_count     <= {{(CYCLE_W-1){1'b0}}, 1'b1};
            target_reg      <= target_cycle;
            busy            <= 1'b1;
            state_reg       <= ST_COUNT;
          end
        end

        ST_COUNT: begin
          cycle_count <= cycle_count + 1'b1;
          // A target of 0 would otherwise wait a full counter wrap.
          if ((target_reg == '0) || (cycle_count == target_reg)) begin
            state_reg   <= ST_CHECK;
            chk_cnt_reg <= '0;
            rf_rd_addr  <= tbl_rd_addr;
            cur_en_reg  <= tbl_rd_en;
            cur_exp_reg <= tbl_rd_data;
            cur_idx_reg <= tbl_rd_idx;
          end
        end

        ST_CHECK: begin
          // Stage 2: judge the value sampled in the previous cycle.
          if (cmp_mismatch) begin
            if (fail_count == '0) begin
              first_fail_idx  <= cmp_idx_reg;
              first_fail_data <= cmp_act_reg;
            end
            if (fail_count != NUM_C) begin
              fail_count <= fail_count + 1'b1;
            end
          end

          // Stage 1: sample the register file for the entry on the bus.
          if (chk_cnt_reg < NUM_C) begin
            cmp_valid_reg <= 1'b1;
            cmp_en_reg    <= cur_en_reg;
            cmp_exp_reg   <= cur_exp_reg;
            cmp_act_reg   <= rf_rd_data;
            cmp_idx_reg   <= cur_idx_reg;
          end

          if (next_slot_ok) begin
            rf_rd_addr  <= tbl_rd_addr;
            cur_en_reg  <= tbl_rd_en;
            cur_exp_reg <= tbl_rd_data;
            cur_idx_reg <= tbl_rd_idx;
          end

          chk_cnt_reg <= chk_cnt_reg + 1'b1;

          if (chk_cnt_reg == NUM_C) begin
            state_reg <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= (fail_count == '0) && !cmp_mismatch;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pipe_check_monitor.md
PIPE_CHECK_MONITOR -- requirements
Module: pipe_check_monitor

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter REG_ADDR_W, default 5, register-file address width.
REQ-003 SHALL have parameter NUM_CHECKS, default 8, number of check entries; IDX_W = clog2(NUM_CHECKS).
REQ-004 SHALL have parameter CYCLE_W, default 32, cycle counter width.
REQ-005 SHALL have port clk  in  1  single clock; all logic on the rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port cfg_we  in  1  writes one check entry.
REQ-008 SHALL have port cfg_idx  in  IDX_W  entry index.
REQ-009 SHALL have port cfg_en  in  1  entry enable.
REQ-010 SHALL have port cfg_addr  in  REG_ADDR_W  register to check.
REQ-011 SHALL have port cfg_data  in  DATA_W  expected value.
REQ-012 SHALL have port target_cycle  in  CYCLE_W  cycle at which checking starts.
REQ-013 SHALL have port start  in  1  single-cycle start pulse.
REQ-014 SHALL have port rf_rd_addr  out  REG_ADDR_W  register-file read address, registered.
REQ-015 SHALL have port rf_rd_data  in  DATA_W  combinational register-file read data.
REQ-016 SHALL have ports busy, done, pass  out  1 each: run active, results valid, all enabled checks matched.
REQ-017 SHALL have ports fail_count  out  IDX_W+1; first_fail_idx  out  IDX_W; first_fail_data  out  DATA_W (actual value read).
REQ-018 SHALL have port cycle_count  out  CYCLE_W  current run cycle.

Function
REQ-019 SHALL implement FSM states IDLE, COUNT, CHECK, DONE.
REQ-020 SHALL write cfg_en/cfg_addr/cfg_data to entry cfg_idx on cfg_we only in IDLE or DONE; cfg_we in COUNT/CHECK SHALL be ignored.
REQ-021 SHALL, on start in IDLE or DONE: clear done, pass, fail_count, first_fail_*; load cycle_count = 1; go to COUNT.
REQ-022 SHALL ignore start in COUNT and CHECK.
REQ-023 SHALL, in COUNT, increment cycle_count each cycle (wrap modulo 2^CYCLE_W) and go to CHECK in the cycle after cycle_count == target_cycle.
REQ-024 SHALL treat target_cycle = 0 or 1 as "check immediately": CHECK entered the cycle after start.
REQ-025 SHALL, in CHECK, present entry i's address on rf_rd_addr in CHECK cycle i and compare rf_rd_data against entry i's expected value in CHECK cycle i+1; CHECK lasts exactly NUM_CHECKS+1 cycles.
REQ-026 SHALL skip comparison for disabled entries (no fail counted); entries still consume one slot each.
REQ-027 SHALL, on a mismatch, increment fail_count (saturating at NUM_CHECKS) and capture first_fail_idx/first_fail_data for the first mismatch only.
REQ-028 SHALL, after the last comparison, enter DONE with done = 1 and pass = (fail_count == 0); zero enabled entries gives pass = 1.
REQ-029 SHALL hold busy = 1 in COUNT and CHECK, 0 otherwise; cycle_count SHALL freeze outside COUNT.
REQ-030 SHALL hold all results stable in DONE until the next accepted start.

Reset
REQ-031 SHALL, with rst_n low at a rising edge, force IDLE; busy, done, pass = 0; fail_count, first_fail_idx, first_fail_data, cycle_count, rf_rd_addr = 0; all entry enables = 0.
REQ-032 SHALL abort any run on reset mid-COUNT or mid-CHECK with no partial results visible afterwards.

Structure
REQ-033 SHALL place the FSM state enum and parameter defaults in shared package pipe_check_pkg.
REQ-034 SHALL implement the entry storage as sub-module check_table (NUM_CHECKS entries, one write port, one indexed read port).

Verification
REQ-035 SHALL cover: entries 0..4 = (19,5),(20,10),(21,3),(22,25),(23,28), RF matching, target 11, start -> CHECK entered after cycle_count 11, done 6 cycles later, pass = 1, fail_count = 0.
REQ-036 SHALL cover: same with RF[22] = 24 -> pass = 0, fail_count = 1, first_fail_idx = 3, first_fail_data = 24.
REQ-037 SHALL cover: entries 1 and 3 disabled, RF[20] and RF[22] wrong -> pass = 1.
REQ-038 SHALL cover: target_cycle = 0 -> CHECK starts the cycle after start; start and cfg_we during COUNT -> no effect on the run.
REQ-039 SHALL cover: rst_n low during CHECK -> IDLE, all outputs 0; a following start with no new cfg writes -> pass = 1, fail_count = 0.
